dram_wb_arbiter: RTL and testbench



---
 rtl/dram_wb_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_dram_wb_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dram_wb_arbiter.sv
// ---------------------------------------------------------------------------
// dram_wb_arbiter
//   Round-robin Wishbone arbiter in front of the DRAM controller slave port.
//   One master owns the bus for its whole cyc window, so bursts stay intact.
//   A watchdog aborts strobes the DRAM side never acknowledges, for example
//   while calibration is still running. The master then sees an err pulse
//   and the arbiter drains until that master drops cyc.
//
// Ports
//   user_clk_i, rst_i       : clock, synchronous active-high reset
//   m_cyc/stb/we_i          : per-master Wishbone control, one bit per master
//   m_addr_i, m_data_i      : packed per-master address / write data
//                             (master k at [k*W +: W])
//   m_data_o                : read data, broadcast to all masters
//   m_ack_o, m_err_o        : per-master ack / timeout error pulse
//   s_*                     : single Wishbone master port toward the DRAM ctrl
//   grant_o                 : one-hot current owner
//   busy_o                  : high while a master owns or drains the bus
// ---------------------------------------------------------------------------

// Per-master response gating: only the owner sees the ack or err.
module dram_wb_arb_port (
    input  logic own,
    input  logic ack,
    input  logic tmo,
    output logic ack_o,
    output logic err_o
);
    assign ack_o = own & ack;
    assign err_o = own & tmo;
endmodule

module dram_wb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_WIDTH     = 27,
    parameter int WORD_SIZE      = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              user_clk_i,
    input  logic                              rst_i,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NUM_MASTERS*WORD_SIZE-1:0]  m_data_i,
    output logic [WORD_SIZE-1:0]              m_data_o,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [ADDR_WIDTH-1:0]             s_addr_o,
    output logic [WORD_SIZE-1:0]              s_data_o,
    input  logic [WORD_SIZE-1:0]              s_data_i,
    input  logic                              s_ack_i,
    output logic [NUM_MASTERS-1:0]            grant_o,
    output logic                              busy_o
);

    localparam int                     PW       = $clog2(NUM_MASTERS);
    localparam logic [15:0]            WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_MASTERS-1:0] ONE      = NUM_MASTERS'(1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          last_ptr_q, last_ptr_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [15:0]            wd_cnt_q, wd_cnt_d;

    logic [NUM_MASTERS-1:0] req;
    logic                   pick_vld;
    logic [PW-1:0]          pick_idx;
    logic                   in_grant;
    logic                   owner_cyc;
    logic                   fwd_ack;
    logic                   timeout;

    logic [ADDR_WIDTH-1:0]  addr_arr [NUM_MASTERS];
    logic [WORD_SIZE-1:0]   data_arr [NUM_MASTERS];

    assign req = m_cyc_i & m_stb_i;

    // Round-robin pick: scan from last_ptr+1 upward with wrap. The loop runs
    // from the far end back toward last_ptr+1 so the nearest requester is
    // the last one assigned and wins.
    always_comb begin
        int      idx;
        logic [PW-1:0] cand;
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        cand     = '0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            idx  = (int'(last_ptr_q) + i) % NUM_MASTERS;
            cand = PW'(idx);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Owner-side muxes, selected by the registered grant index.
    assign in_grant  = (state_q == S_GRANT);
    assign owner_cyc = m_cyc_i[last_ptr_q];

    assign s_cyc_o  = in_grant & owner_cyc;
    assign s_stb_o  = in_grant & owner_cyc & m_stb_i[last_ptr_q];
    assign s_we_o   = in_grant & owner_cyc & m_we_i[last_ptr_q];
    assign s_addr_o = in_grant ? addr_arr[last_ptr_q] : '0;
    assign s_data_o = in_grant ? data_arr[last_ptr_q] : '0;

    // Ack at the watchdog limit wins over the abort.
    assign fwd_ack = in_grant & s_ack_i;
    assign timeout = s_stb_o & ~s_ack_i & (wd_cnt_q == WD_LIMIT);

    assign m_data_o = s_data_i;
    assign grant_o  = grant_q;
    assign busy_o   = (state_q != S_IDLE);

    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_port
        assign addr_arr[k] = m_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_arr[k] = m_data_i[k*WORD_SIZE +: WORD_SIZE];

        dram_wb_arb_port u_port (
            .own   (grant_q[k]),
            .ack   (fwd_ack),
            .tmo   (timeout),
            .ack_o (m_ack_o[k]),
            .err_o (m_err_o[k])
        );
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_ptr_d = last_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d    = S_GRANT;
                    grant_d    = ONE << pick_idx;
                    last_ptr_d = pick_idx;
                end
            end
            S_GRANT: begin
                if (!owner_cyc) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end else if (timeout) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!owner_cyc) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase

        // Counts consecutive stalled strobe cycles; anything else restarts it.
        if (in_grant && (state_d == S_GRANT) && s_stb_o && !s_ack_i)
            wd_cnt_d = wd_cnt_q + 16'd1;
        else
            wd_cnt_d = '0;
    end

    always_ff @(posedge user_clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            last_ptr_q <= PW'(NUM_MASTERS - 1);
            wd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_ptr_q <= last_ptr_d;
            wd_cnt_q   <= wd_cnt_d;
        end
    end

endmodule

// File: tb/tb_dram_wb_arbiter.sv
module tb_dram_wb_arbiter;

    localparam int N  = 4;
    localparam int AW = 27;
    localparam int DW = 256;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      m_cyc, m_stb, m_we;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_wdata;
    logic [DW-1:0]     m_rdata;
    logic [N-1:0]      m_ack, m_err;
    logic              s_cyc, s_stb, s_we;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata, s_rdata;
    logic              s_ack;
    logic [N-1:0]      grant;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dram_wb_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .WORD_SIZE(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .user_clk_i (clk),
        .rst_i      (rst),
        .m_cyc_i    (m_cyc),
        .m_stb_i    (m_stb),
        .m_we_i     (m_we),
        .m_addr_i   (m_addr),
        .m_data_i   (m_wdata),
        .m_data_o   (m_rdata),
        .m_ack_o    (m_ack),
        .m_err_o    (m_err),
        .s_cyc_o    (s_cyc),
        .s_stb_o    (s_stb),
        .s_we_o     (s_we),
        .s_addr_o   (s_addr),
        .s_data_o   (s_wdata),
        .s_data_i   (s_rdata),
        .s_ack_i    (s_ack),
        .grant_o    (grant),
        .busy_o     (busy)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [DW-1:0] pat_a5;
        int order [5];
        order  = '{0, 1, 2, 3, 0};
        pat_a5 = {32{8'hA5}};

        rst = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0;
        m_addr = '0; m_wdata = '0; s_rdata = '0; s_ack = 1'b0;
        step(); step();
        settle();
        chk("rst_grant", grant, 4'b0000);
        chk("rst_busy",  busy,  1'b0);
        chk("rst_scyc",  {s_stb, s_cyc, s_we}, 3'b000);
        chk("rst_ack_err", {m_ack, m_err}, 8'h00);
        chk("rst_rdata", m_rdata, '0);

        // ---- single request: master 2 read @0x100, ack 3 cycles later ----
        rst = 1'b0;
        m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
        m_addr[2*AW +: AW] = 27'h100;
        settle();
        chk("t1_idle_grant", grant, 4'b0000);
        step(); settle();
        chk("t1_grant", grant, 4'b0100);
        chk("t1_scyc_stb_we", {s_cyc, s_stb, s_we}, 3'b110);
        chk("t1_saddr", s_addr, 27'h100);
        chk("t1_noack0", m_ack, 4'b0000);
        step(); settle();
        chk("t1_noack1", m_ack, 4'b0000);
        step(); settle();
        chk("t1_noack2", m_ack, 4'b0000);
        step();
        s_ack = 1'b1; s_rdata = pat_a5;
        settle();
        chk("t1_ack", m_ack, 4'b0100);
        chk("t1_rdata", m_rdata, pat_a5);
        chk("t1_noerr", m_err, 4'b0000);
        step();
        s_ack = 1'b0; m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
        settle();
        chk("t1_drop_scyc", s_cyc, 1'b0);
        chk("t1_drop_ack", m_ack, 4'b0000);
        chk("t1_drop_busy", busy, 1'b1);
        step(); settle();
        chk("t1_idle_busy", busy, 1'b0);
        chk("t1_idle_grant2", grant, 4'b0000);

        // ---- contention: reset pointer, all four request continuously ----
        rst = 1'b1;
        step();
        rst = 1'b0; m_cyc = 4'hF; m_stb = 4'hF;
        step();
        for (int i = 0; i < 5; i++) begin
            s_ack = 1'b1;
            settle();
            chk($sformatf("t2_grant%0d", i), grant, 4'b0001 << order[i]);
            chk($sformatf("t2_ack%0d", i), m_ack, 4'b0001 << order[i]);
            step();
            s_ack = 1'b0;
            m_cyc[order[i]] = 1'b0; m_stb[order[i]] = 1'b0;
            settle();
            chk($sformatf("t2_rel_scyc%0d", i), s_cyc, 1'b0);
            chk($sformatf("t2_rel_grant%0d", i), grant, 4'b0001 << order[i]);
            step();
            // dead IDLE cycle; an ack here must not leak to anyone
            s_ack = 1'b1;
            if (i < 4) begin m_cyc = 4'hF; m_stb = 4'hF; end
            else       begin m_cyc = 4'h0; m_stb = 4'h0; end
            settle();
            chk($sformatf("t2_dead_grant%0d", i), grant, 4'b0000);
            chk($sformatf("t2_dead_ack%0d", i), m_ack, 4'b0000);
            step();
        end
        s_ack = 1'b0;

        // ---- burst hold: master 1 4-beat write while master 0 waits ----
        m_cyc = 4'b0011; m_stb = 4'b0011; m_we = 4'b0010;
        m_addr[0*AW +: AW] = 27'h22; m_addr[1*AW +: AW] = 27'h11;
        m_wdata[0*DW +: DW] = {32{8'h0F}}; m_wdata[1*DW +: DW] = {32{8'h3C}};
        step();
        for (int b = 0; b < 4; b++) begin
            s_ack = 1'b1;
            settle();
            chk($sformatf("t3_grant_b%0d", b), grant, 4'b0010);
            chk($sformatf("t3_ack_b%0d", b), m_ack, 4'b0010);
            step();
        end
        chk("t3_saddr", s_addr, 27'h11);
        chk("t3_swdata", s_wdata, {32{8'h3C}});
        chk("t3_swe", s_we, 1'b1);
        s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_we = '0;
        step(); settle();
        chk("t3_dead", grant, 4'b0000);
        step(); settle();
        chk("t3_m0_grant", grant, 4'b0001);
        chk("t3_m0_addr", s_addr, 27'h22);
        m_cyc = '0; m_stb = '0;
        step(); step(); settle();
        chk("t3_idle", busy, 1'b0);

        // ---- timeout: master 3, slave never acks ----
        m_cyc[3] = 1'b1; m_stb[3] = 1'b1;
        step();
        for (int s = 1; s < TO; s++) begin
            settle();
            chk($sformatf("t4_noerr%0d", s), m_err, 4'b0000);
            step();
        end
        settle();
        chk("t4_err", m_err, 4'b1000);
        chk("t4_err_scyc", s_cyc, 1'b1);
        step();
        s_ack = 1'b1;
        settle();
        chk("t4_drain_sctl", {s_cyc, s_stb, s_we}, 3'b000);
        chk("t4_drain_ack", m_ack, 4'b0000);
        chk("t4_drain_err", m_err, 4'b0000);
        chk("t4_drain_busy_grant", {busy, grant}, 5'b1_1000);
        step(); settle();
        chk("t4_drain_hold", busy, 1'b1);
        s_ack = 1'b0; m_cyc[3] = 1'b0; m_stb[3] = 1'b0;
        step(); settle();
        chk("t4_idle", {busy, grant}, 5'b0_0000);

        // ---- ack exactly at the limit: master 1 ----
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        step();
        for (int s = 1; s < TO; s++) step();
        s_ack = 1'b1;
        settle();
        chk("t5_ack", m_ack, 4'b0010);
        chk("t5_noerr", m_err, 4'b0000);
        step();
        s_ack = 1'b0;
        settle();
        chk("t5_still_grant", {busy, grant, s_cyc}, 6'b1_0010_1);
        // counter restarted: error only on the 8th new stalled cycle
        for (int s = 1; s < TO; s++) begin
            settle();
            chk($sformatf("t5_noerr%0d", s), m_err, 4'b0000);
            step();
        end
        settle();
        chk("t5_err", m_err, 4'b0010);
        step();
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        step(); settle();
        chk("t5_idle", busy, 1'b0);

        // ---- reset in the middle of master 3's burst ----
        m_cyc[3] = 1'b1; m_stb[3] = 1'b1;
        step(); settle();
        chk("t6_grant", grant, 4'b1000);
        s_ack = 1'b1;
        rst = 1'b1;
        step(); settle();
        chk("t6_rst_ctl", {grant, busy, s_cyc, s_stb, s_we}, 8'h00);
        chk("t6_rst_resp", {m_ack, m_err}, 8'h00);
        chk("t6_rst_saddr", s_addr, 27'h0);
        rst = 1'b0; s_ack = 1'b0;
        m_cyc = 4'hF; m_stb = 4'hF;
        step(); settle();
        chk("t6_first_m0", grant, 4'b0001);
        m_cyc = '0; m_stb = '0;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
